weight_feeder: RTL and testbench

// - Upstream end of the PE weight path. Produces the packed 144-bit kernel word
//   and the 2-bit cal_state that weight_controller consumes and de-rotates.
// - Accepts 3 kernel rows per kernel (48b each = 3 x 16b weights) over a

---
 rtl/weight_feeder.sv | 121 ++++++++++++
 tb/tb_weight_feeder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/weight_feeder.sv
// weight_feeder
//   Upstream end of the PE weight path. Collects three 48-bit kernel rows
//   per kernel from the weight buffer into a shadow bank. When a full
//   shadow kernel is ready and the active slot is free (idle, or being
//   retired by kernel_done), the shadow bank is copied into the active
//   bank. The active bank drives weight_out. A 3-phase rotation counter
//   (cal_state) steps on row_adv pulses for the downstream
//   weight_controller.
//
// Ports
//   clk          in   1     rising-edge clock
//   reset        in   1     synchronous, active-high
//   wr_valid     in   1     row beat present on wr_data
//   wr_ready     out  1     shadow bank can take a beat (combinational)
//   wr_data      in   48    one kernel row; beat n -> shadow slot n
//   row_adv      in   1     advance cal_state one phase
//   kernel_done  in   1     active kernel retired
//   weight_out   out  144   {A2,A1,A0}, A0 in the low 48 bits
//   cal_state    out  2     rotation phase 0..2
//   weight_valid out  1     weight_out/cal_state hold a live kernel
//   err_adv      out  1     sticky: row_adv seen with no live kernel
module weight_feeder #(
  parameter int DATA_W = 16,
  parameter int K      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [K*DATA_W-1:0]   wr_data,
  input  logic                  row_adv,
  input  logic                  kernel_done,
  output logic [K*K*DATA_W-1:0] weight_out,
  output logic [1:0]            cal_state,
  output logic                  weight_valid,
  output logic                  err_adv
);

  localparam int         ROW_W     = K * DATA_W;
  localparam logic [1:0] LAST_BEAT = 2'(K - 1);
  localparam logic [1:0] LAST_PH   = 2'(K - 1);

  logic [ROW_W-1:0] shadow0;
  logic [ROW_W-1:0] shadow1;
  logic [ROW_W-1:0] shadow2;
  logic             shadow_full;
  logic [1:0]       wcnt;

  logic accept;
  logic swap;

  // wr_ready is the only combinational output; it drops during reset so
  // no beat can be counted while the bank is being cleared.
  assign wr_ready = !reset && !shadow_full;
  assign accept   = wr_valid && wr_ready;

  // A full shadow bank moves in as soon as the active slot is free. When
  // kernel_done arrives with a full shadow, the new kernel replaces the
  // old one on the same edge, so weight_valid never drops.
  assign swap = shadow_full && (!weight_valid || kernel_done);

  // Shadow bank and beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow0     <= '0;
      shadow1     <= '0;
      shadow2     <= '0;
      shadow_full <= 1'b0;
      wcnt        <= 2'd0;
    end else begin
      if (accept) begin
        case (wcnt)
          2'd0:    shadow0 <= wr_data;
          2'd1:    shadow1 <= wr_data;
          2'd2:    shadow2 <= wr_data;
          default: ;
        endcase
        if (wcnt == LAST_BEAT) begin
          wcnt        <= 2'd0;
          shadow_full <= 1'b1;
        end else begin
          wcnt <= wcnt + 2'd1;
        end
      end
      // accept and swap are mutually exclusive: accept needs !shadow_full.
      if (swap) begin
        shadow_full <= 1'b0;
      end
    end
  end

  // Active bank, validity and rotation phase
  always_ff @(posedge clk) begin
    if (reset) begin
      weight_out   <= '0;
      weight_valid <= 1'b0;
      cal_state    <= 2'd0;
    end else if (swap) begin
      weight_out   <= {shadow2, shadow1, shadow0};
      weight_valid <= 1'b1;
      cal_state    <= 2'd0;
    end else if (kernel_done && weight_valid) begin
      // Retire with nothing queued: keep the old words on the bus, just
      // mark them stale. kernel_done outranks a simultaneous row_adv.
      weight_valid <= 1'b0;
      cal_state    <= 2'd0;
    end else if (row_adv && weight_valid) begin
      cal_state <= (cal_state == LAST_PH) ? 2'd0 : cal_state + 2'd1;
    end
  end

  // Sticky misuse flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      err_adv <= 1'b0;
    end else if (row_adv && !weight_valid) begin
      err_adv <= 1'b1;
    end
  end

endmodule

// File: tb/tb_weight_feeder.sv
module tb_weight_feeder;

  logic         clk;
  logic         reset;
  logic         wr_valid;
  logic         wr_ready;
  logic [47:0]  wr_data;
  logic         row_adv;
  logic         kernel_done;
  logic [143:0] weight_out;
  logic [1:0]   cal_state;
  logic         weight_valid;
  logic         err_adv;

  weight_feeder dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .row_adv      (row_adv),
    .kernel_done  (kernel_done),
    .weight_out   (weight_out),
    .cal_state    (cal_state),
    .weight_valid (weight_valid),
    .err_adv      (err_adv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [143:0] got,
                           input logic [143:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: rows queued until three are present, then the whole
  // kernel moves to the active slot; phase is a plain modulo-3 count.
  logic [47:0]  m_rows[$];
  logic [143:0] m_act;
  bit           m_valid;
  int           m_phase;
  bit           m_err;

  task automatic model_step();
    bit acc, swp, was_valid;
    if (reset) begin
      m_rows.delete();
      m_act   = '0;
      m_valid = 0;
      m_phase = 0;
      m_err   = 0;
      return;
    end
    was_valid = m_valid;
    acc = wr_valid && (m_rows.size() < 3);
    swp = (m_rows.size() == 3) && (!was_valid || kernel_done);
    if (acc) m_rows.push_back(wr_data);
    if (swp) begin
      m_act   = {m_rows[2], m_rows[1], m_rows[0]};
      m_rows.delete();
      m_valid = 1;
      m_phase = 0;
    end else if (kernel_done && was_valid) begin
      m_valid = 0;
      m_phase = 0;
    end else if (row_adv && was_valid) begin
      m_phase = (m_phase + 1) % 3;
    end
    if (row_adv && !was_valid) m_err = 1;
  endtask

  task automatic compare_all();
    check_val("weight_out", weight_out, m_act);
    check_val("weight_valid", weight_valid, m_valid);
    check_val("cal_state", cal_state, m_phase[1:0]);
    check_val("err_adv", err_adv, m_err);
  endtask

  // Called at a falling edge: apply inputs, check wr_ready, clock once,
  // step the model, then compare registered outputs at the next falling edge.
  task automatic drive(input logic r, input logic v, input logic [47:0] d,
                       input logic ra, input logic kd);
    reset = r; wr_valid = v; wr_data = d; row_adv = ra; kernel_done = kd;
    #1;
    check_val("wr_ready", wr_ready, !r && (m_rows.size() < 3));
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  localparam logic [47:0] A0 = 48'h1111_1111_1111;
  localparam logic [47:0] A1 = 48'h2222_2222_2222;
  localparam logic [47:0] A2 = 48'h3333_3333_3333;
  localparam logic [47:0] B0 = 48'hB000_0000_00B0;
  localparam logic [47:0] B1 = 48'hB111_1111_11B1;
  localparam logic [47:0] B2 = 48'hB222_2222_22B2;
  localparam logic [47:0] C0 = 48'hC0C0_0000_1234;
  localparam logic [47:0] C1 = 48'hC1C1_1111_5678;
  localparam logic [47:0] C2 = 48'hC2C2_2222_9ABC;

  initial begin
    int exp_ph[4];
    logic [63:0] rnd;
    exp_ph = '{1, 2, 0, 1};
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; row_adv = 1'b0; kernel_done = 1'b0;
    m_act = '0;
    @(negedge clk);

    // Reset state
    drive(1, 0, '0, 0, 0);
    drive(1, 1, A0, 1, 1);
    check_val("rst_weight_out", weight_out, 144'd0);
    check_val("rst_valid", weight_valid, 1'b0);
    check_val("rst_cal", cal_state, 2'd0);
    check_val("rst_err", err_adv, 1'b0);

    // Kernel A from idle: valid two cycles after the third beat
    drive(0, 1, A0, 0, 0);
    drive(0, 1, A1, 0, 0);
    drive(0, 1, A2, 0, 0);
    check_val("a_not_yet_valid", weight_valid, 1'b0);
    check_val("a_ready_low_full", wr_ready, 1'b0);
    drive(0, 0, '0, 0, 0);
    check_val("a_valid", weight_valid, 1'b1);
    check_val("a_weight_out", weight_out, {A2, A1, A0});
    check_val("a_cal", cal_state, 2'd0);

    // Four row_adv pulses
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, '0, 1, 0);
      check_val("phase_seq", cal_state, exp_ph[i][1:0]);
      check_val("phase_hold_out", weight_out, {A2, A1, A0});
    end

    // Kernel B loads behind A, then swaps on kernel_done with no gap
    drive(0, 1, B0, 0, 0);
    check_val("b_no_gap", weight_valid, 1'b1);
    drive(0, 1, B1, 0, 0);
    check_val("b_no_gap", weight_valid, 1'b1);
    drive(0, 1, B2, 0, 0);
    check_val("b_no_gap", weight_valid, 1'b1);
    check_val("b_ready_low", wr_ready, 1'b0);
    drive(0, 1, A0, 0, 0);
    check_val("b_ready_low_hold", wr_ready, 1'b0);
    check_val("b_still_a", weight_out, {A2, A1, A0});
    drive(0, 0, '0, 0, 1);
    check_val("b_swap_out", weight_out, {B2, B1, B0});
    check_val("b_swap_valid", weight_valid, 1'b1);
    check_val("b_swap_cal", cal_state, 2'd0);

    // kernel_done with empty shadow, then row_adv on a dead kernel
    drive(0, 0, '0, 1, 0);
    drive(0, 0, '0, 0, 1);
    check_val("kd_empty_valid", weight_valid, 1'b0);
    check_val("kd_empty_cal", cal_state, 2'd0);
    check_val("kd_empty_out", weight_out, {B2, B1, B0});
    drive(0, 0, '0, 1, 0);
    check_val("dead_adv_err", err_adv, 1'b1);
    check_val("dead_adv_cal", cal_state, 2'd0);

    // row_adv and kernel_done together at phase 2
    drive(0, 1, A2, 0, 0);
    drive(0, 1, A1, 0, 0);
    drive(0, 1, A0, 0, 0);
    drive(0, 0, '0, 0, 0);
    drive(0, 0, '0, 1, 0);
    drive(0, 0, '0, 1, 0);
    check_val("both_pre_cal", cal_state, 2'd2);
    drive(0, 0, '0, 1, 1);
    check_val("both_cal", cal_state, 2'd0);
    check_val("both_valid", weight_valid, 1'b0);

    // Reset mid-load discards partial beats
    drive(0, 1, B0, 0, 0);
    drive(0, 1, B1, 0, 0);
    drive(1, 0, '0, 0, 0);
    drive(0, 1, C0, 0, 0);
    drive(0, 1, C1, 0, 0);
    drive(0, 1, C2, 0, 0);
    drive(0, 0, '0, 0, 0);
    check_val("c_weight_out", weight_out, {C2, C1, C0});
    check_val("c_valid", weight_valid, 1'b1);
    check_val("c_err", err_adv, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rnd = {$urandom(), $urandom()};
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), rnd[47:0],
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) < 3));
      check_val("cal_range", (cal_state != 2'd3), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
